// File: rtl/vga_frame_ctrl.sv
// Pixel-domain read-path sequencer (flush / prefill / run) with frame-aligned double-buffer flipping.
// Define VGA_UNDERFLOW_RECOVERY_EN to restart the read path on FIFO underflow; otherwise underflows are only counted.
module vga_frame_ctrl #(
    parameter logic [31:0] BASE0        = 32'h0000_0000,
    parameter logic [31:0] BASE1        = 32'h0017_7000,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        enable,
    input  logic        fifo_full_sync,
    input  logic        fifo_empty,
    input  logic        rd_req,
    input  logic        frame_end,
    input  logic        swap_req,
    input  logic        clr_cnt,
    output logic        timing_run,
    output logic        fifo_flush,
    output logic        buf_sel,
    output logic [31:0] base_adr,
    output logic        swap_ack,
    output logic [15:0] underflow_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        PREFILL = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

    state_t        cur;
    logic [CW-1:0] flush_cnt;
    logic          armed;
    logic          swap_pend;
    logic          underflow;
    logic          swap_take;
    logic          swap_commit;
    logic          recover;

    assign state = cur;

    // An accepted request is held in swap_pend so it survives swap_req dropping before frame_end.
    always_comb begin
        underflow   = (cur == RUN) && rd_req && fifo_empty;
        swap_take   = swap_pend || (swap_req && armed);
        swap_commit = swap_take &&
                      ((cur == IDLE) || (cur == FLUSH) || ((cur == RUN) && frame_end));
    end

`ifdef VGA_UNDERFLOW_RECOVERY_EN
    assign recover = underflow;
`else
    assign recover = 1'b0;
`endif

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            cur           <= IDLE;
            timing_run    <= 1'b0;
            fifo_flush    <= 1'b0;
            flush_cnt     <= '0;
            buf_sel       <= 1'b0;
            base_adr      <= BASE0;
            swap_ack      <= 1'b0;
            armed         <= 1'b1;
            swap_pend     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            if (clr_cnt)
                underflow_cnt <= '0;
            else if (underflow && (underflow_cnt != '1))
                underflow_cnt <= underflow_cnt + 16'd1;

            swap_ack <= swap_commit;
            if (swap_commit) begin
                buf_sel   <= ~buf_sel;
                base_adr  <= buf_sel ? BASE0 : BASE1;
                armed     <= 1'b0;
                swap_pend <= 1'b0;
            end else begin
                swap_pend <= swap_take;
                if (!swap_req)
                    armed <= 1'b1;
            end

            if (!enable) begin
                cur        <= IDLE;
                timing_run <= 1'b0;
                fifo_flush <= 1'b0;
                flush_cnt  <= '0;
            end else begin
                case (cur)
                    IDLE: begin
                        cur        <= FLUSH;
                        fifo_flush <= 1'b1;
                        flush_cnt  <= '0;
                    end
                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST) begin
                            cur        <= PREFILL;
                            fifo_flush <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    PREFILL: begin
                        if (fifo_full_sync) begin
                            cur        <= RUN;
                            timing_run <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (recover) begin
                            cur        <= FLUSH;
                            timing_run <= 1'b0;
                            fifo_flush <= 1'b1;
                            flush_cnt  <= '0;
                        end
                    end
                    default: begin
                        cur        <= IDLE;
                        timing_run <= 1'b0;
                        fifo_flush <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl: vector table, directed corner sequences, and randomized run against a behavioural model.
module tb_vga_frame_ctrl;

    localparam int          FLUSH_N = 16;
    localparam logic [31:0] B0      = 32'h0000_0000;
    localparam logic [31:0] B1      = 32'h0017_7000;

    logic        pixel_clk;
    logic        pixel_rst;
    logic        enable, fifo_full_sync, fifo_empty, rd_req, frame_end, swap_req, clr_cnt;
    logic        timing_run, fifo_flush, buf_sel, swap_ack;
    logic [31:0] base_adr;
    logic [15:0] underflow_cnt;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1;

    vga_frame_ctrl #(
        .BASE0(B0),
        .BASE1(B1),
        .FLUSH_CYCLES(FLUSH_N)
    ) dut (
        .pixel_clk(pixel_clk),
        .pixel_rst(pixel_rst),
        .enable(enable),
        .fifo_full_sync(fifo_full_sync),
        .fifo_empty(fifo_empty),
        .rd_req(rd_req),
        .frame_end(frame_end),
        .swap_req(swap_req),
        .clr_cnt(clr_cnt),
        .timing_run(timing_run),
        .fifo_flush(fifo_flush),
        .buf_sel(buf_sel),
        .base_adr(base_adr),
        .swap_ack(swap_ack),
        .underflow_cnt(underflow_cnt),
        .state(state)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    // Behavioural model: phase 0..3, flush as a countdown of remaining flush cycles, swap as a wish flag.
    int m_phase, m_flush_left, m_cnt;
    bit m_buf, m_ack, m_armed, m_want;

    task automatic model_reset();
        m_phase = 0; m_flush_left = 0; m_cnt = 0;
        m_buf = 0; m_ack = 0; m_armed = 1; m_want = 0;
    endtask

    task automatic model_edge();
        bit uf, take, commit;
        uf     = (m_phase == 3) && rd_req && fifo_empty;
        take   = m_want || (swap_req && m_armed);
        commit = take && (m_phase <= 1 || (m_phase == 3 && frame_end));
        if (clr_cnt) m_cnt = 0;
        else if (uf && m_cnt < 65535) m_cnt = m_cnt + 1;
        m_ack = commit;
        if (commit) begin
            m_buf = !m_buf; m_armed = 0; m_want = 0;
        end else begin
            m_want = take;
            if (!swap_req) m_armed = 1;
        end
        if (!enable) begin
            m_phase = 0; m_flush_left = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_flush_left = FLUSH_N;
        end else if (m_phase == 1) begin
            m_flush_left = m_flush_left - 1;
            if (m_flush_left == 0) m_phase = 2;
        end else if (m_phase == 2) begin
            if (fifo_full_sync) m_phase = 3;
        end else begin
`ifdef VGA_UNDERFLOW_RECOVERY_EN
            if (uf) begin m_phase = 1; m_flush_left = FLUSH_N; end
`endif
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("m_state",   32'(state),         32'(m_phase));
        check("m_run",     32'(timing_run),    32'(m_phase == 3));
        check("m_flush",   32'(fifo_flush),    32'(m_flush_left > 0));
        check("m_buf",     32'(buf_sel),       32'(m_buf));
        check("m_base",    base_adr,           m_buf ? B1 : B0);
        check("m_ack",     32'(swap_ack),      32'(m_ack));
        check("m_cnt",     32'(underflow_cnt), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge pixel_clk);
        model_edge();
        #1;
        if (chk_en) cmp_model();
    endtask

    task automatic set_in(input bit en, input bit full, input bit empty, input bit rd,
                          input bit fe, input bit sw, input bit clr);
        enable = en; fifo_full_sync = full; fifo_empty = empty; rd_req = rd;
        frame_end = fe; swap_req = sw; clr_cnt = clr;
    endtask

    task automatic do_reset();
        #2 pixel_rst = 1'b1;
        model_reset();
        #1;
        cmp_model();
        #1 pixel_rst = 1'b0;
    endtask

    task automatic go_run();
        int n;
        n = 0;
        set_in(1, 1, 0, 0, 0, 0, 0);
        while (state != 2'd3 && n < 60) begin
            step();
            n++;
        end
        check("go_run_reaches_run", 32'(state), 32'd3);
    endtask

    typedef struct {
        int       reps;
        bit       en, full, empty, rd, fe, sw, clr;
        bit [1:0] st;
        bit       run, fl, bs, ack;
        bit [15:0] cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int acks, ack_at;

        tbl[0]  = '{2,  0,0,0,0,0,0,0, 2'd0, 0,0,0,0, 16'd0};
        tbl[1]  = '{16, 1,0,0,0,0,0,0, 2'd1, 0,1,0,0, 16'd0};
        tbl[2]  = '{1,  1,0,0,0,0,0,0, 2'd2, 0,0,0,0, 16'd0};
        tbl[3]  = '{2,  1,0,0,0,0,0,0, 2'd2, 0,0,0,0, 16'd0};
        tbl[4]  = '{1,  1,1,0,0,0,0,0, 2'd3, 1,0,0,0, 16'd0};
        tbl[5]  = '{4,  1,1,0,1,0,0,0, 2'd3, 1,0,0,0, 16'd0};
        tbl[6]  = '{2,  1,1,1,0,0,0,0, 2'd3, 1,0,0,0, 16'd0};
        tbl[7]  = '{3,  1,1,0,0,0,1,0, 2'd3, 1,0,0,0, 16'd0};
        tbl[8]  = '{1,  1,1,0,0,1,1,0, 2'd3, 1,0,1,1, 16'd0};
        tbl[9]  = '{1,  1,1,0,0,1,1,0, 2'd3, 1,0,1,0, 16'd0};
        tbl[10] = '{1,  1,1,0,0,0,0,0, 2'd3, 1,0,1,0, 16'd0};
        tbl[11] = '{2,  1,1,0,0,0,1,0, 2'd3, 1,0,1,0, 16'd0};
        tbl[12] = '{1,  1,1,0,0,1,0,0, 2'd3, 1,0,0,1, 16'd0};
        tbl[13] = '{1,  1,1,0,0,0,0,0, 2'd3, 1,0,0,0, 16'd0};
        tbl[14] = '{1,  0,0,0,0,0,0,0, 2'd0, 0,0,0,0, 16'd0};

        pixel_rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check("rst_state", 32'(state),         32'd0);
        check("rst_run",   32'(timing_run),    32'd0);
        check("rst_flush", 32'(fifo_flush),    32'd0);
        check("rst_buf",   32'(buf_sel),       32'd0);
        check("rst_base",  base_adr,           B0);
        check("rst_ack",   32'(swap_ack),      32'd0);
        check("rst_cnt",   32'(underflow_cnt), 32'd0);
        #1 pixel_rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].en, tbl[i].full, tbl[i].empty, tbl[i].rd, tbl[i].fe, tbl[i].sw, tbl[i].clr);
            for (int r = 0; r < tbl[i].reps; r++) begin
                step();
                check($sformatf("tbl%0d_state", i), 32'(state),         32'(tbl[i].st));
                check($sformatf("tbl%0d_run", i),   32'(timing_run),    32'(tbl[i].run));
                check($sformatf("tbl%0d_flush", i), 32'(fifo_flush),    32'(tbl[i].fl));
                check($sformatf("tbl%0d_buf", i),   32'(buf_sel),       32'(tbl[i].bs));
                check($sformatf("tbl%0d_base", i),  base_adr,           tbl[i].bs ? B1 : B0);
                check($sformatf("tbl%0d_ack", i),   32'(swap_ack),      32'(tbl[i].ack));
                check($sformatf("tbl%0d_cnt", i),   32'(underflow_cnt), 32'(tbl[i].cnt));
            end
        end

        // Held swap request in RUN: exactly one flip, at the first frame_end.
        go_run();
        step();
        acks = 0; ack_at = -1;
        for (int i = 0; i < 300; i++) begin
            set_in(1, 1, 0, 0, (i == 250 || i == 280), 1, 0);
            step();
            if (swap_ack) begin acks++; ack_at = i; end
        end
        check("hold_ack_count", 32'(acks),    32'd1);
        check("hold_ack_cycle", 32'(ack_at),  32'd250);
        check("hold_buf",       32'(buf_sel), 32'd1);
        check("hold_base",      base_adr,     B1);

        // Swap in IDLE commits immediately.
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        swap_req = 1'b1;
        step();
        check("idle_swap_ack",  32'(swap_ack), 32'd1);
        check("idle_swap_buf",  32'(buf_sel),  32'd0);
        check("idle_swap_base", base_adr,      B0);
        swap_req = 1'b0;
        step();
        check("idle_swap_ack_off", 32'(swap_ack), 32'd0);

        // Three underflow cycles in RUN.
        go_run();
        clr_cnt = 1'b1;
        step();
        set_in(1, 1, 1, 1, 0, 0, 0);
        repeat (3) step();
`ifdef VGA_UNDERFLOW_RECOVERY_EN
        check("uf3_cnt",   32'(underflow_cnt), 32'd1);
        check("uf3_state", 32'(state),         32'd1);
        check("uf3_run",   32'(timing_run),    32'd0);
`else
        check("uf3_cnt",   32'(underflow_cnt), 32'd3);
        check("uf3_state", 32'(state),         32'd3);
`endif

        // frame_end + armed swap + underflow in one cycle.
        go_run();
        clr_cnt = 1'b1;
        step();
        set_in(1, 1, 1, 1, 1, 1, 0);
        step();
        check("sim_ack", 32'(swap_ack),      32'd1);
        check("sim_buf", 32'(buf_sel),       32'd1);
        check("sim_cnt", 32'(underflow_cnt), 32'd1);
`ifdef VGA_UNDERFLOW_RECOVERY_EN
        check("sim_state", 32'(state), 32'd1);
`else
        check("sim_state", 32'(state), 32'd3);
`endif

`ifndef VGA_UNDERFLOW_RECOVERY_EN
        // Saturation and clear-over-increment.
        go_run();
        clr_cnt = 1'b1;
        step();
        set_in(1, 1, 1, 1, 0, 0, 0);
        chk_en = 0;
        repeat (65535) step();
        chk_en = 1;
        check("sat_reach", 32'(underflow_cnt), 32'hFFFF);
        step();
        check("sat_hold",  32'(underflow_cnt), 32'hFFFF);
        check("sat_state", 32'(state),         32'd3);
        clr_cnt = 1'b1;
        step();
        check("sat_clr_wins", 32'(underflow_cnt), 32'd0);
`endif

        // enable drop in the fifth flush cycle.
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        enable = 1'b1;
        repeat (5) step();
        check("abort_in_flush", 32'(fifo_flush), 32'd1);
        enable = 1'b0;
        step();
        check("abort_state", 32'(state),      32'd0);
        check("abort_flush", 32'(fifo_flush), 32'd0);

        // Asynchronous reset in RUN.
        go_run();
        set_in(1, 1, 1, 1, 0, 0, 0);
        step();
        set_in(1, 1, 0, 0, 0, 0, 0);
        do_reset();
        check("arst_state", 32'(state),         32'd0);
        check("arst_run",   32'(timing_run),    32'd0);
        check("arst_flush", 32'(fifo_flush),    32'd0);
        check("arst_buf",   32'(buf_sel),       32'd0);
        check("arst_base",  base_adr,           B0);
        check("arst_ack",   32'(swap_ack),      32'd0);
        check("arst_cnt",   32'(underflow_cnt), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                set_in($urandom_range(0, 99) < 97, $urandom_range(0, 9) < 3,
                       $urandom_range(0, 9) < 3,   $urandom_range(0, 1) == 1,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3,
                       $urandom_range(0, 49) == 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
